// File: rtl/uart_reg_responder_if.sv
// uart_reg_responder_if: byte-link and register-bus signals between a host-side agent (master)
// and the register-access responder (slave).
interface uart_reg_responder_if;
    logic [7:0] rxdata;
    logic       rxdone;
    logic [7:0] txdata;
    logic       txstart;
    logic       txbusy;
    logic       txdone;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // Host side: feeds received bytes, owns the transmitter and the register file.
    modport master (
        output rxdata, rxdone, txbusy, txdone, reg_rdata,
        input  txdata, txstart, reg_addr, reg_wdata, reg_we, reg_re
    );

    // Responder side.
    modport slave (
        input  rxdata, rxdone, txbusy, txdone, reg_rdata,
        output txdata, txstart, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: parses 'W' addr data / 'R' addr command frames arriving over a UART byte
// link, performs the 8-bit register access and answers ACK/NAK (plus read data) through the
// transmit handshake.
// Build macro UART_REG_CHECKSUM_EN: every frame ends with an XOR checksum byte (GET_SUM state),
// a bad checksum is answered with NAK and no bus access, and read replies gain (ACK ^ data).
module uart_reg_responder #(
    parameter int unsigned TIMEOUT = 100_000,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52,
    parameter logic [7:0]  ACK     = 8'h06,
    parameter logic [7:0]  NAK     = 8'h15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_reg_responder_if.slave bus_io,
    output logic                busy_o,
    output logic                drop_o
);

    // Counter holds 0..TIMEOUT-1; the frame is abandoned on the cycle it would reach TIMEOUT.
    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

`ifdef UART_REG_CHECKSUM_EN
    localparam logic [1:0] RdRespLen = 2'd3;
`else
    localparam logic [1:0] RdRespLen = 2'd2;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
`ifdef UART_REG_CHECKSUM_EN
        StGetSum,
`endif
        StExec,
        StRdLatch,
        StSend,
        StWaitTx
    } state_e;

    // State entered once the last payload byte of a frame has arrived.
`ifdef UART_REG_CHECKSUM_EN
    localparam state_e StFrameEnd = StGetSum;
`else
    localparam state_e StFrameEnd = StExec;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_rd_q, is_rd_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            nak_q, nak_d;
    logic [1:0]      len_q, len_d;
    logic [1:0]      idx_q, idx_d;
`ifdef UART_REG_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic       rx_done;
    logic [7:0] rx_data;
    logic       reg_we;
    logic       reg_re;
    logic       tx_start;
    logic       drop;
    logic [7:0] tx_byte;

    assign rx_done = bus_io.rxdone;
    assign rx_data = bus_io.rxdata;

    // Next-state, frame parsing, timeout and response sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        is_rd_d  = is_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        nak_d    = nak_q;
        len_d    = len_q;
        idx_d    = idx_q;
`ifdef UART_REG_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        reg_we   = 1'b0;
        reg_re   = 1'b0;
        tx_start = 1'b0;
        drop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_done) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_rd_d = (rx_data == CMD_RD);
                        state_d = StGetAddr;
                    end else begin
                        nak_d   = 1'b1;
                        len_d   = 2'd1;
                        idx_d   = 2'd0;
                        state_d = StSend;
                    end
                end
            end

            StGetAddr: begin
                if (rx_done) begin
                    addr_d  = rx_data;
                    state_d = is_rd_q ? StFrameEnd : StGetData;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StGetData: begin
                if (rx_done) begin
                    wdata_d = rx_data;
                    state_d = StFrameEnd;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_REG_CHECKSUM_EN
            StGetSum: begin
                if (rx_done) begin
                    if (rx_data == sum_q) begin
                        state_d = StExec;
                    end else begin
                        nak_d   = 1'b1;
                        len_d   = 2'd1;
                        idx_d   = 2'd0;
                        state_d = StSend;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            StExec: begin
                drop = rx_done;
                if (is_rd_q) begin
                    reg_re  = 1'b1;
                    state_d = StRdLatch;
                end else begin
                    reg_we  = 1'b1;
                    nak_d   = 1'b0;
                    len_d   = 2'd1;
                    idx_d   = 2'd0;
                    state_d = StSend;
                end
            end

            StRdLatch: begin
                // Read data is valid exactly one cycle after the strobe.
                drop    = rx_done;
                rdata_d = bus_io.reg_rdata;
                nak_d   = 1'b0;
                len_d   = RdRespLen;
                idx_d   = 2'd0;
                state_d = StSend;
            end

            StSend: begin
                drop = rx_done;
                if (!bus_io.txbusy) begin
                    tx_start = 1'b1;
                    state_d  = StWaitTx;
                end
            end

            StWaitTx: begin
                drop = rx_done;
                if (bus_io.txdone) begin
                    if (idx_q + 2'd1 == len_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StSend;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

`ifdef UART_REG_CHECKSUM_EN
        // Running XOR of the command and payload bytes, compared against the trailing byte.
        if (rx_done) begin
            if (state_q == StIdle) begin
                sum_d = rx_data;
            end else if (state_q == StGetAddr || state_q == StGetData) begin
                sum_d = sum_q ^ rx_data;
            end
        end
`endif
    end

    // Reply byte selected by position within the response.
    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            2'd0:    tx_byte = nak_q ? NAK : ACK;
            2'd1:    tx_byte = rdata_q;
            default: tx_byte = ACK ^ rdata_q;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            is_rd_q <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            nak_q   <= 1'b0;
            len_q   <= 2'd0;
            idx_q   <= 2'd0;
`ifdef UART_REG_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nak_q   <= nak_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
`ifdef UART_REG_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // TXDATA is only meaningful while a reply byte is being offered or sent.
    assign bus_io.txdata    = (state_q == StSend || state_q == StWaitTx) ? tx_byte : 8'h00;
    assign bus_io.txstart   = tx_start;
    assign bus_io.reg_addr  = addr_q;
    assign bus_io.reg_wdata = wdata_q;
    assign bus_io.reg_we    = reg_we;
    assign bus_io.reg_re    = reg_re;
    assign busy_o           = (state_q != StIdle);
    assign drop_o           = drop;

endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: randomized frame stimulus against a frame-level reference model
// (register image plus expected reply byte list), with a bus/transmitter agent and a monitor.
module tb_uart_reg_responder;
    localparam int unsigned TO    = 40;
    localparam logic [7:0]  CmdWr = 8'h57;
    localparam logic [7:0]  CmdRd = 8'h52;
    localparam logic [7:0]  Ack   = 8'h06;
    localparam logic [7:0]  Nak   = 8'h15;
`ifdef UART_REG_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic clk;
    logic rst;
    logic busy;
    logic drop;

    uart_reg_responder_if bus ();

    uart_reg_responder #(
        .TIMEOUT (TO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus),
        .busy_o (busy),
        .drop_o (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register images: dev_mem is what the bus agent serves, ref_mem is the model's view.
    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];

    int         cyc = 0;
    int         last_rx_cyc = -100;
    int         we_cyc = -100;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         drop_cnt = 0;
    int         start_cnt = 0;
    logic [7:0] last_we_addr, last_we_data, last_re_addr;
    logic [7:0] tx_log [$];
    bit         re_prev = 1'b0;
    logic [7:0] re_prev_addr = 8'h00;
    bit         tx_active = 1'b0;
    bit         tx_abort = 1'b0;

    // Monitor: strobes, latencies and transmit requests, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.reg_we) begin
                we_cnt++;
                last_we_addr = bus.reg_addr;
                last_we_data = bus.reg_wdata;
                dev_mem[bus.reg_addr] = bus.reg_wdata;
                we_cyc = cyc;
                if (!rst) chk("we_latency", cyc - last_rx_cyc, 1);
            end
            if (bus.reg_re) begin
                re_cnt++;
                last_re_addr = bus.reg_addr;
                if (!rst) chk("re_latency", cyc - last_rx_cyc, 1);
            end
            if (bus.rxdone) last_rx_cyc = cyc;
            if (drop) drop_cnt++;
            if (bus.txstart) begin
                start_cnt++;
                tx_log.push_back(bus.txdata);
                chk("start_while_busy", bus.txbusy, 0);
                chk("start_after_we", cyc > we_cyc, 1);
            end
            re_prev      = bus.reg_re;
            re_prev_addr = bus.reg_addr;
        end
    end

    // Register file read port: data valid exactly one cycle after REG_RE, garbage otherwise.
    initial begin
        bus.reg_rdata = 8'h00;
        forever begin
            tick();
            bus.reg_rdata = re_prev ? dev_mem[re_prev_addr] : 8'($urandom);
        end
    end

    // Transmitter: random busy time, TXDONE pulse, busy sometimes lingering past TXDONE.
    initial begin
        logic [7:0] held;
        bus.txbusy = 1'b0;
        bus.txdone = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.txstart && !rst) begin
                held      = bus.txdata;
                tx_active = 1'b1;
                tick();
                bus.txbusy = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 bus.txdone = 1'b1;
                @(negedge clk);
                if (!tx_abort) chk("tx_hold", bus.txdata, held);
                tick();
                bus.txdone = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1 bus.txbusy = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called aligned just after a rising edge; returns aligned after `idle` empty cycles.
    task automatic send_byte(input logic [7:0] b, input int idle);
        bus.rxdata = b;
        bus.rxdone = 1'b1;
        tick();
        bus.rxdone = 1'b0;
        bus.rxdata = 8'($urandom);
        repeat (idle) tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_txstart"}, bus.txstart, 0);
        chk({tag, "_txdata"}, bus.txdata, 0);
        chk({tag, "_we"}, bus.reg_we, 0);
        chk({tag, "_re"}, bus.reg_re, 0);
        chk({tag, "_addr"}, bus.reg_addr, 0);
        chk({tag, "_wdata"}, bus.reg_wdata, 0);
    endtask

    // kind: 0 write, 1 read, 2 unknown command, 3 frame abandoned by silence.
    task automatic run_frame(input int kind, input logic [7:0] a, input logic [7:0] d,
                             input bit do_drop, input bit bad_sum, input int first_idle);
        logic [7:0] fr [$];
        logic [7:0] exp_tx [$];
        logic [7:0] s, v;
        int         we0, re0, dr0, st0, n_send, exp_we, exp_re, idle;
        bit         bad, done;
        bad    = bad_sum && CsumEn;
        we0    = we_cnt;
        re0    = re_cnt;
        dr0    = drop_cnt;
        st0    = start_cnt;
        exp_we = 0;
        exp_re = 0;
        tx_log.delete();

        if (kind == 2) begin
            v = d;
            if (v == CmdWr || v == CmdRd) v = 8'h41;
            fr.push_back(v);
            exp_tx.push_back(Nak);
        end else begin
            fr.push_back((kind == 1) ? CmdRd : CmdWr);
            fr.push_back(a);
            if (kind != 1) fr.push_back(d);
            if (CsumEn) begin
                s = 8'h00;
                foreach (fr[i]) s ^= fr[i];
                fr.push_back(bad ? (s ^ (8'h01 << $urandom_range(0, 7))) : s);
            end
            if (kind == 3) begin
                // No reply and no access expected.
            end else if (bad) begin
                exp_tx.push_back(Nak);
            end else if (kind == 0) begin
                ref_mem[a] = d;
                exp_we = 1;
                exp_tx.push_back(Ack);
            end else begin
                v = ref_mem[a];
                exp_re = 1;
                exp_tx.push_back(Ack);
                exp_tx.push_back(v);
                if (CsumEn) exp_tx.push_back(Ack ^ v);
            end
        end

        n_send = (kind == 3) ? fr.size() - 1 : fr.size();
        for (int i = 0; i < n_send; i++) begin
            if (i == n_send - 1) idle = 0;
            else if (i == 0 && first_idle > 0) idle = first_idle;
            else idle = $urandom_range(0, 3);
            send_byte(fr[i], idle);
        end
        if (kind == 3) repeat (TO + 4) tick();

        if (do_drop) begin
            for (int k = 0; k < 500 && start_cnt == st0; k++) tick();
            chk("drop_wait", start_cnt != st0, 1);
            send_byte(8'($urandom), 0);
        end

        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            done = !busy && !tx_active;
        end
        chk("frame_done", done, 1);

        chk("tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk("tx_byte", tx_log[i], exp_tx[i]);
        chk("we_count", we_cnt - we0, exp_we);
        if (exp_we != 0) begin
            chk("we_addr", last_we_addr, a);
            chk("we_data", last_we_data, d);
        end
        chk("re_count", re_cnt - re0, exp_re);
        if (exp_re != 0) chk("re_addr", last_re_addr, a);
        chk("drop_count", drop_cnt - dr0, do_drop);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int         kind, st0, re0, we0;
        logic [7:0] a;
        bit         done;

        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            dev_mem[i] = a;
            ref_mem[i] = a;
        end
        dev_mem[8'h3C] = 8'h5A;
        ref_mem[8'h3C] = 8'h5A;

        rst        = 1'b1;
        bus.rxdata = 8'h00;
        bus.rxdone = 1'b0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        run_frame(0, 8'h10, 8'hA5, 1'b0, 1'b0, 0);
        run_frame(1, 8'h3C, 8'h00, 1'b0, 1'b0, 0);
        run_frame(2, 8'h00, 8'h41, 1'b0, 1'b0, 0);
        run_frame(0, 8'h10, 8'h00, 1'b0, 1'b0, 0);
        run_frame(3, 8'h10, 8'h77, 1'b0, 1'b0, 0);
        run_frame(1, 8'h01, 8'h00, 1'b0, 1'b0, 0);
        run_frame(0, 8'h22, 8'h5E, 1'b1, 1'b0, 0);
        run_frame(1, 8'h22, 8'h00, 1'b1, 1'b0, 0);
        // Byte arriving on the very cycle the timeout would expire is still accepted.
        run_frame(0, 8'h44, 8'hC3, 1'b0, 1'b0, TO - 1);
        run_frame(1, 8'h44, 8'h00, 1'b0, 1'b0, TO - 1);
`ifdef UART_REG_CHECKSUM_EN
        run_frame(0, 8'h10, 8'hA5, 1'b0, 1'b0, 0);
        run_frame(0, 8'h10, 8'h3B, 1'b0, 1'b1, 0);
        run_frame(1, 8'h10, 8'h00, 1'b0, 1'b0, 0);
`endif

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) kind = 0;
            else if (kind <= 6 || kind == 9) kind = 1;
            else if (kind == 7) kind = 2;
            else kind = 3;
            run_frame(kind, 8'($urandom), 8'($urandom),
                      (kind != 3) && ($urandom_range(0, 3) == 0),
                      (kind < 2) && ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 5) == 0) ? int'(TO - 1) : 0);
        end

        // Reset while waiting for write data.
        we0 = we_cnt;
        st0 = start_cnt;
        send_byte(CmdWr, 1);
        send_byte(8'h5D, 2);
        rst = 1'b1;
        tick();
        chk_outputs_zero("rst_getdata");
        rst = 1'b0;
        repeat (TO + 4) tick();
        chk("rst_getdata_we", we_cnt - we0, 0);
        chk("rst_getdata_tx", start_cnt - st0, 0);
        chk("rst_getdata_busy", busy, 0);
        run_frame(0, 8'h5D, 8'h81, 1'b0, 1'b0, 0);

        // Reset while the first reply byte of a read is in the transmitter.
        re0 = re_cnt;
        st0 = start_cnt;
        send_byte(CmdRd, 0);
        send_byte(8'h5D, 0);
        if (CsumEn) send_byte(CmdRd ^ 8'h5D, 0);
        for (int k = 0; k < 500 && start_cnt == st0; k++) tick();
        tx_abort = 1'b1;
        rst      = 1'b1;
        tick();
        chk_outputs_zero("rst_waittx");
        rst = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            done = !tx_active;
        end
        chk("rst_waittx_txdrain", done, 1);
        repeat (8) tick();
        tx_abort = 1'b0;
        chk("rst_waittx_starts", start_cnt - st0, 1);
        chk("rst_waittx_re", re_cnt - re0, 1);
        chk("rst_waittx_busy", busy, 0);
        run_frame(1, 8'h5D, 8'h00, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
